// File: rtl/btb_pkg.sv
// btb_pkg: shared BTB widths, entry format and controller states
package btb_pkg;
  localparam int IDX_W = 7;
  localparam int TAG_W = 7;
  localparam int TGT_W = 12;
  localparam int BTB_DEPTH = 128;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] tgt;
  } btb_entry_t;
  typedef enum logic {INIT, RUN} btb_state_t;
endpackage

// File: rtl/btb_ctrl.sv
// btb_ctrl: clears the BTB array after reset, then turns lookups into reads and updates into writes
module btb_ctrl #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 7,
  parameter int TAG_W = 7,
  parameter int TGT_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lk_valid,
  output logic                   lk_ready,
  input  logic [PC_W-1:0]        lk_pc,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic [PC_W-1:0]        rsp_target,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [PC_W-1:0]        upd_pc,
  input  logic [PC_W-1:0]        upd_target,
  input  logic                   upd_taken,
  output logic                   arr_csb0,
  output logic [IDX_W-1:0]       arr_addr0,
  output logic [TAG_W+TGT_W:0]   arr_din0,
  output logic                   arr_csb1,
  output logic [IDX_W-1:0]       arr_addr1,
  input  logic [TAG_W+TGT_W:0]   arr_dout1
);
  import btb_pkg::*;
  btb_state_t state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic lk_acc, upd_acc, rsp_byp;
  logic [TAG_W-1:0] rsp_tag;
  logic [PC_W-TGT_W-3:0] rsp_hi;
  btb_entry_t byp_ent, ent;
  logic unused;
  assign unused = ^{lk_pc[1:0], upd_pc[1:0], upd_pc[PC_W-1:IDX_W+TAG_W+2], upd_target[1:0], upd_target[PC_W-1:TGT_W+2]};
  // state register and init sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == INIT) ? cnt + 1'b1 : '0;
    end
  end
  // next state, handshakes, array port drive and response selection with same-cycle bypass
  always_comb begin
    state_nxt  = (state == INIT && &cnt) ? RUN : state;
    lk_ready   = state == RUN && !rst;
    upd_ready  = state == RUN && !rst;
    lk_acc     = lk_valid && lk_ready;
    upd_acc    = upd_valid && upd_ready;
    arr_csb0   = !(state == INIT || upd_acc);
    arr_addr0  = (state == INIT) ? cnt : upd_acc ? upd_pc[IDX_W+1:2] : '0;
    arr_din0   = upd_acc ? {upd_taken, upd_pc[IDX_W+TAG_W+1:IDX_W+2], upd_target[TGT_W+1:2]} : '0;
    arr_csb1   = !lk_acc;
    arr_addr1  = lk_acc ? lk_pc[IDX_W+1:2] : '0;
    ent        = rsp_byp ? byp_ent : arr_dout1;
    rsp_hit    = rsp_valid && ent.valid && ent.tag == rsp_tag;
    rsp_target = rsp_hit ? {rsp_hi, ent.tgt, 2'b00} : '0;
  end
  // capture lookup context; a same-index update in the same cycle is remembered for bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= lk_acc;
      if (lk_acc) begin
        rsp_tag <= lk_pc[IDX_W+TAG_W+1:IDX_W+2];
        rsp_hi  <= lk_pc[PC_W-1:TGT_W+2];
        rsp_byp <= upd_acc && upd_pc[IDX_W+1:2] == lk_pc[IDX_W+1:2];
        byp_ent <= arr_din0;
      end
    end
  end
endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: scoreboard bench for btb_ctrl with a behavioural 128x20 array beside it
module tb_btb_ctrl;
  logic clk = 0, rst = 1;
  logic lk_valid = 0, lk_ready, rsp_valid, rsp_hit;
  logic [31:0] lk_pc = 0, rsp_target, upd_pc = 0, upd_target = 0;
  logic upd_valid = 0, upd_ready, upd_taken = 0;
  logic arr_csb0, arr_csb1;
  logic [6:0] arr_addr0, arr_addr1;
  logic [19:0] arr_din0, arr_dout1;
  logic [19:0] mem [128];
  int total = 0, bad = 0, cyc = 0;
  bit run = 0;
  typedef struct {int due; logic hit; logic [31:0] tgt;} exp_t;
  exp_t sb [$];
  logic m_v [128];
  logic [6:0] m_tag [128];
  logic [11:0] m_tgt [128];

  btb_ctrl dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pc(lk_pc),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_target(rsp_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .arr_csb0(arr_csb0), .arr_addr0(arr_addr0), .arr_din0(arr_din0),
    .arr_csb1(arr_csb1), .arr_addr1(arr_addr1), .arr_dout1(arr_dout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // array model: read returns pre-write contents; idle cycles scramble dout
  always @(posedge clk) begin
    arr_dout1 <= !arr_csb1 ? mem[arr_addr1] : 20'($urandom);
    if (!arr_csb0) mem[arr_addr0] <= arr_din0;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        chk("rsp_target", rsp_target, e.tgt);
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 0);
      end
    end
  end

  task automatic drive(bit lv, logic [31:0] lpc, bit uv = 0, logic [31:0] upc = 0,
                       logic [31:0] utgt = 0, bit utk = 1);
    exp_t e;
    int i;
    lk_valid = lv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk;
    if (run) begin
      if (uv) begin
        i = int'(upc[8:2]);
        m_v[i] = utk; m_tag[i] = upc[15:9]; m_tgt[i] = utgt[13:2];
      end
      if (lv) begin
        i = int'(lpc[8:2]);
        e.due = cyc + 1;
        e.hit = m_v[i] && m_tag[i] == lpc[15:9];
        e.tgt = e.hit ? {lpc[31:14], m_tgt[i], 2'b00} : 32'h0;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic init_chk();
    for (int i = 0; i < 128; i++) begin
      lk_valid = 1; lk_pc = 32'h1000;
      upd_valid = 1; upd_pc = 32'h44; upd_target = 32'h88; upd_taken = 1;
      @(negedge clk);
      chk("init_lk_ready", 32'(lk_ready), 0);
      chk("init_upd_ready", 32'(upd_ready), 0);
      chk("init_csb0", 32'(arr_csb0), 0);
      chk("init_addr0", 32'(arr_addr0), i);
      chk("init_din0", 32'(arr_din0), 0);
      chk("init_csb1", 32'(arr_csb1), 1);
      @(posedge clk); #1;
    end
    lk_valid = 0; upd_valid = 0;
    @(negedge clk);
    chk("run_lk_ready", 32'(lk_ready), 1);
    chk("run_upd_ready", 32'(upd_ready), 1);
    @(posedge clk); #1;
    run = 1;
  endtask

  task automatic do_reset();
    rst = 1; run = 0; sb.delete();
    lk_valid = 1; lk_pc = 32'h2468;
    upd_valid = 1; upd_pc = 32'h2468; upd_target = 32'h3FFC; upd_taken = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    for (int i = 0; i < 128; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end
    init_chk();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 20'h80000 | 20'($urandom);
    @(posedge clk); #1;
    do_reset();
    drive(1, 32'h1000); drive(0, 0);
    drive(0, 0, 1, 32'h2468, 32'h3A0C, 1); drive(0, 0);
    drive(1, 32'h2468); drive(0, 0);
    drive(1, 32'h104, 1, 32'h104, 32'h200, 1); drive(0, 0);
    drive(0, 0, 1, 32'h10, 32'h5550, 1); drive(0, 0);
    drive(1, 32'h210); drive(1, 32'h10);
    drive(0, 0, 1, 32'h10, 32'h5550, 0); drive(0, 0);
    drive(1, 32'h10); drive(0, 0);
    drive(1, 32'h2468); drive(1, 32'h1000); drive(1, 32'h104); drive(1, 32'h210); drive(0, 0);
    drive(1, 32'hFFFF_C468); drive(0, 0);
    for (int k = 0; k < 300; k++)
      drive(1'($urandom), $urandom & 32'hC000_060C, 1'($urandom), $urandom & 32'hC000_060C,
            $urandom, 1'($urandom_range(0, 3) != 0));
    drive(0, 0);
    drive(1, 32'h2468);
    do_reset();
    drive(1, 32'h2468); drive(1, 32'h104); drive(0, 0); drive(0, 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
